// File: rtl/mc_alu.sv
// Multicycle ALU: single-cycle logic/add/shift ops, WIDTH-step shift-add multiply and restoring divide.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 for MUL/MULH/DIVU/REMU; start is ignored outside IDLE (no queuing).
module mc_alu #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);
  localparam int           MSB      = WIDTH - 1;

  state_t             state, state_nxt;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [SHW:0]       cnt_q;

  logic               is_iter, take, last;
  logic [WIDTH:0]     sum, dif;
  logic [WIDTH-1:0]   s_y;
  logic               s_c, s_v;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, step_nxt;
  logic [WIDTH:0]     r_sh, r_sub;
  logic               r_ge;
  logic [WIDTH-1:0]   it_y;
  logic               it_v, it_d;

  assign is_iter = (op[3:2] == 2'b10);
  assign take    = (state == IDLE) && start;
  assign last    = (state == RUN) && (cnt_q == CNT_LAST);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Single-cycle datapath, evaluated straight from the input operands.
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    s_y = '0;
    s_c = 1'b0;
    s_v = 1'b0;
    case (op)
      4'd0: begin
        s_y = sum[WIDTH-1:0];
        s_c = sum[WIDTH];
        s_v = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      4'd1: begin
        s_y = dif[WIDTH-1:0];
        s_c = ~dif[WIDTH];
        s_v = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);
      end
      4'd2: s_y = a & b;
      4'd3: s_y = a | b;
      4'd4: s_y = a ^ b;
      4'd5: s_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd6: s_y = a << b[SHW-1:0];
      4'd7: s_y = a >> b[SHW-1:0];
      default: ;
    endcase
  end

  // acc_q holds {product high, multiplier/low} for MUL and {remainder, quotient} for DIV.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

  assign r_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign r_ge    = (r_sh >= {1'b0, opnd_q});
  assign r_sub   = r_sh - {1'b0, opnd_q};
  assign div_nxt = {(r_ge ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], r_ge};

  assign step_nxt = op_q[1] ? div_nxt : mul_nxt;
  assign it_y     = op_q[0] ? step_nxt[2*WIDTH-1:WIDTH] : step_nxt[WIDTH-1:0];
  assign it_v     = (op_q == 4'd8) && (|step_nxt[2*WIDTH-1:WIDTH]);
  assign it_d     = op_q[1] && (opnd_q == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = is_iter ? RUN : DONE;
      RUN:     if (cnt_q == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      opnd_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else if (take && is_iter) begin
      op_q   <= op;
      opnd_q <= op[1] ? b : a;
      acc_q  <= {{WIDTH{1'b0}}, (op[1] ? a : b)};
      cnt_q  <= CNT_INIT;
    end else if (state == RUN) begin
      acc_q  <= step_nxt;
      cnt_q  <= cnt_q - CNT_LAST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y           <= '0;
      zero        <= 1'b0;
      carry       <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (take && !is_iter) begin
      y           <= s_y;
      zero        <= (s_y == '0);
      carry       <= s_c;
      overflow    <= s_v;
      div_by_zero <= 1'b0;
    end else if (last) begin
      y           <= it_y;
      zero        <= (it_y == '0);
      carry       <= 1'b0;
      overflow    <= it_v;
      div_by_zero <= it_d;
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// Bench for mc_alu (WIDTH=16): vector table through a scoreboard queue, plus mid-run start and reset sequences.
module tb_mc_alu;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, zero, carry, overflow, div_by_zero;
  logic [W-1:0] y;

  mc_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .y(y), .zero(zero), .carry(carry),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    logic        z, c, v, d;
  } vec_t;

  typedef struct {
    logic [15:0] y;
    logic        z, c, v, d;
    int          lat;
    int          bsy;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] o, input logic [15:0] ia, input logic [15:0] ib,
                              input logic [15:0] ey, input logic ez, input logic ec,
                              input logic ev, input logic ed);
    vec_t v;
    v.op = o; v.a = ia; v.b = ib; v.y = ey;
    v.z = ez; v.c = ec; v.v = ev; v.d = ed;
    return v;
  endfunction

  // Drive one operation, push its expectation, wait (bounded) for done and score it.
  task automatic issue(input vec_t v, input bit inject, input string tag);
    exp_t e, g;
    bit   iter, got;
    int   n, nb;
    iter  = (v.op >= 4'd8) && (v.op <= 4'd11);
    e.y   = v.y; e.z = v.z; e.c = v.c; e.v = v.v; e.d = v.d;
    e.lat = iter ? 17 : 1;
    e.bsy = iter ? 16 : 0;
    @(posedge clk); #1;
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    sb.push_back(e);
    n = 0; nb = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      start = inject && (n == 5);
      op = inject && (n == 5) ? 4'd0 : 4'($urandom);
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (busy) nb++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk({tag, " done seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, " sb nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        g = sb.pop_front();
        chk({tag, " y"},        32'(y),           32'(g.y));
        chk({tag, " zero"},     32'(zero),        32'(g.z));
        chk({tag, " carry"},    32'(carry),       32'(g.c));
        chk({tag, " overflow"}, 32'(overflow),    32'(g.v));
        chk({tag, " dbz"},      32'(div_by_zero), 32'(g.d));
        chk({tag, " latency"},  32'(n),           32'(g.lat));
        chk({tag, " busy cyc"}, 32'(nb),          32'(g.bsy));
      end
      @(posedge clk); #1;
      chk({tag, " done pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    int dcnt;
    //          op     a        b        y        z     c     v     d
    tbl.push_back(mk(4'd0,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(4'd0,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(4'd1,  16'd25,   16'd25,   16'h0000, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(4'd1,  16'd5,    16'd7,    16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'd1,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(4'd2,  16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'd3,  16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'd4,  16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'd5,  16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'd5,  16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'd6,  16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'd7,  16'h8000, 16'h0013, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'd13, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'd8,  16'd1023, 16'd780,  16'h2CF4, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(4'd9,  16'd1023, 16'd780,  16'h000C, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'd8,  16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(4'd9,  16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'd10, 16'd1023, 16'd10,   16'h0066, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'd11, 16'd1023, 16'd10,   16'h0003, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'd10, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'd11, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'd10, 16'd200,  16'd0,    16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(4'd11, 16'd200,  16'd0,    16'h00C8, 1'b0, 1'b0, 1'b0, 1'b1));

    #2;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst y",    32'(y),    32'd0);
    chk("rst flags", 32'({zero, carry, overflow, div_by_zero}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) issue(tbl[i], (tbl[i].op == 4'd8), $sformatf("v%0d", i));

    // Reset in the middle of a MUL: everything clears without a clock edge and no done follows.
    @(posedge clk); #1;
    start = 1'b1; op = 4'd8; a = 16'd1023; b = 16'd780;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid busy", 32'(busy), 32'd1);
    chk("mid y held", 32'(y), 32'h00C8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst done", 32'(done), 32'd0);
    chk("arst y",    32'(y),    32'd0);
    chk("arst dbz",  32'(div_by_zero), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    chk("no done after rst", 32'(dcnt), 32'd0);

    issue(mk(4'd0, 16'd2, 16'd3, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, "post-rst add");
    chk("sb drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_alu.md
Name: mc_alu

Overview:
- Parametrised, multicycle-capable ALU for the multicycle datapath.
- Successor to the 16-bit, 3-bit-opcode combinational ALU.
- Adds width parameter, 4-bit opcode, carry/overflow flags and iterative multiply/divide (shift-add multiplier, restoring divider).
- Uses a start/busy/done handshake so the control FSM can wait on long operations.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 4, power of two).
- SHW, $clog2(WIDTH), shift-amount field width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  4  operation select, latched with start.
- a  in  WIDTH  operand A, latched with start.
- b  in  WIDTH  operand B, latched with start.
- busy  out  1  high while an iterative op runs.
- done  out  1  one-cycle pulse; result and flags valid from this cycle.
- y  out  WIDTH  result register.
- zero  out  1  y == 0.
- carry  out  1  ADD carry-out / SUB no-borrow (a >= b unsigned); 0 for all other ops.
- overflow  out  1  signed overflow for ADD/SUB; for MUL, set when the upper product half is non-zero; 0 for all other ops.
- div_by_zero  out  1  set for DIVU/REMU when b == 0.

Behaviour:
- Async reset: state=IDLE; busy, done, y, zero, carry, overflow, div_by_zero all 0; operand/iteration registers cleared. Reset mid-operation aborts the operation and produces no done.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT: signed, y = 1 or 0.
  - 6 SLL and 7 SRL (logical): shift by b[SHW-1:0].
  - 8 MUL: low WIDTH bits of the unsigned product. 9 MULH: high WIDTH bits.
  - 10 DIVU: unsigned quotient. 11 REMU: unsigned remainder.
  - 12-15 reserved: y = 0, flags 0, single-cycle latency.
- FSM states: IDLE, RUN, DONE.
  - IDLE & start & op < 8 or op > 11: compute and register the result -> DONE at edge k+1.
  - IDLE & start & op in 8..11: latch operands, counter = WIDTH -> RUN.
  - RUN: one multiply/divide step per clock, WIDTH steps. Busy = 1 for edges k+1..k+WIDTH. Then -> DONE at edge k+WIDTH+1.
  - DONE: done = 1 for exactly one cycle, busy = 0, then -> IDLE.
- start is ignored in RUN and DONE; no queuing. Minimum issue interval is 2 cycles.
- Operands and op are latched at start; input changes afterwards have no effect.
- y and flags are updated only on entry to DONE and hold until the next DONE or reset. zero tracks the registered y.
- Divide by zero: runs the full WIDTH steps. Quotient = all ones, remainder = a, div_by_zero = 1.
- All arithmetic is modulo 2^WIDTH. The MUL internal product is 2*WIDTH bits.

Test Plan (WIDTH=16):
- ADD a=0x7FFF, b=0x0001 -> y=0x8000, overflow=1, carry=0, zero=0; done 1 cycle after start, busy never high.
- SUB a=25, b=25 -> y=0, zero=1, carry=1. SUB a=5, b=7 -> y=0xFFFE, carry=0, overflow=0.
- SLT a=0xFFFF, b=0x0001 -> y=1. SRL a=0x8000, b=0x0013 (amount 3) -> y=0x1000. op=13 -> y=0, flags 0.
- MUL a=1023, b=780 -> y=0x2CF4, overflow=1. MULH with the same operands -> y=0x000C. For both, busy is high for 16 cycles and done arrives exactly 17 cycles after start. A start pulsed mid-run is ignored.
- DIVU a=1023, b=10 -> y=0x0066. REMU -> y=0x0003. DIVU a=200, b=0 -> y=0xFFFF, div_by_zero=1. REMU a=200, b=0 -> y=0x00C8.
- Start a MUL, then drive rst_n low 5 cycles in -> busy, done and y go to 0 immediately with no clock edge. After release, no done appears. A new ADD 2+3 then gives y=5 normally.
